// File: rtl/result_serializer.sv
// Serializes a 32-bit multiplier product into bytes; optional LEADING_ZERO_SKIP_EN starts at the top non-zero byte.
// Latency: first byte valid the cycle after the ready rising edge is sampled; one byte per acknowledged cycle.
// Backpressure: a byte is held stable until out_ack; products arriving while busy are discarded and flagged.
module result_serializer #(
   parameter int MSB_FIRST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   input  logic [31:0] result,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ack,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        dropped
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic        ready_d;
   logic        rise;
   logic [31:0] hold;
   logic [1:0]  idx;
   logic [1:0]  start_idx;
   logic [1:0]  last_idx;
   logic        is_last;

   assign rise     = ready & ~ready_d;
   assign last_idx = (MSB_FIRST != 0) ? 2'd0 : 2'd3;
   assign is_last  = (idx == last_idx);

   // idx is the physical byte number within hold; direction depends on MSB_FIRST
   always_comb begin
      start_idx = (MSB_FIRST != 0) ? 2'd3 : 2'd0;
`ifdef LEADING_ZERO_SKIP_EN
      if (MSB_FIRST != 0) begin
         if (result[31:24] != 8'd0)
            start_idx = 2'd3;
         else if (result[23:16] != 8'd0)
            start_idx = 2'd2;
         else if (result[15:8] != 8'd0)
            start_idx = 2'd1;
         else
            start_idx = 2'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready_d <= 1'b1;
         hold    <= 32'd0;
         idx     <= 2'd0;
         dropped <= 1'b0;
      end else begin
         ready_d <= ready;
         if (rise && (state != IDLE))
            dropped <= 1'b1;
         case (state)
            IDLE: begin
               if (rise) begin
                  hold  <= result;
                  idx   <= start_idx;
                  state <= SEND;
               end
            end
            SEND: begin
               if (out_ack) begin
                  if (is_last)
                     state <= DONE;
                  else if (MSB_FIRST != 0)
                     idx <= idx - 2'd1;
                  else
                     idx <= idx + 2'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      case (idx)
         2'd0:    out_byte = hold[7:0];
         2'd1:    out_byte = hold[15:8];
         2'd2:    out_byte = hold[23:16];
         default: out_byte = hold[31:24];
      endcase
   end

   assign out_valid = (state == SEND);
   assign out_last  = out_valid & is_last;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes per product; a negedge monitor checks bytes, last, done and busy.
module tb_result_serializer;

   localparam int MSB = 1;

   logic        clk;
   logic        rst;
   logic        ready;
   logic [31:0] result;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ack;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        dropped;

   logic        ack_rand;
   logic        ack_force;
   logic        ack_rnd_bit;
   logic        mon_en;

   int          tests;
   int          fails;
   logic [8:0]  exp_q[$];

   result_serializer #(.MSB_FIRST(MSB)) dut (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .result    (result),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .dropped   (dropped)
   );

   assign out_ack = ack_rand ? ack_rnd_bit : ack_force;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      ack_rnd_bit = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ack_rnd_bit = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: which bytes a product produces, in order, with the last flag attached
   task automatic push_product(input logic [31:0] val);
      int n;
      int k;
      n = 4;
`ifdef LEADING_ZERO_SKIP_EN
      if (MSB != 0) begin
         n = 1;
         for (int b = 1; b < 4; b++)
            if ((val >> (8 * b)) != 32'd0) n = b + 1;
      end
`endif
      for (int i = 0; i < n; i++) begin
         k = (MSB != 0) ? (n - 1 - i) : i;
         exp_q.push_back({(i == n - 1), 8'((val >> (8 * k)) & 32'hFF)});
      end
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the capture edge, ready still high
   task automatic pulse_rise(input logic [31:0] val, input bit cap);
      ready = 1'b0;
      @(posedge clk); #1;
      ready  = 1'b1;
      result = val;
      if (cap) push_product(val);
      @(posedge clk); #1;
      result = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: %0d bytes still expected, busy=%b", exp_q.size(), busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor
   initial begin
      logic last_acc;
      logic chk_busy;
      last_acc = 1'b0;
      chk_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("done", 32'(done), 32'(last_acc));
            if (chk_busy) chk("busy_after_done", 32'(busy), 32'd0);
            chk_busy = last_acc;
            last_acc = 1'b0;
            if (out_valid && !rst) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_byte: got %h last=%b with nothing expected", out_byte, out_last);
               end else begin
                  chk("byte", 32'(out_byte), 32'(exp_q[0][7:0]));
                  chk("last", 32'(out_last), 32'(exp_q[0][8]));
                  if (out_ack) begin
                     last_acc = exp_q[0][8];
                     void'(exp_q.pop_front());
                  end
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [31:0] v;
      logic [7:0]  seq [4];
      tests     = 0;
      fails     = 0;
      mon_en    = 1'b0;
      rst       = 1'b1;
      ready     = 1'b0;
      result    = 32'd0;
      ack_rand  = 1'b0;
      ack_force = 1'b0;
      seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_byte", 32'(out_byte), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Full-speed transfer: four consecutive bytes, then done, then idle
      ack_force = 1'b1;
      pulse_rise(32'h12345678, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("seq_valid", 32'(out_valid), 32'd1);
         chk("seq_byte", 32'(out_byte), 32'(seq[i]));
         chk("seq_last", 32'(out_last), 32'(i == 3));
         @(posedge clk); #1;
         ready = 1'b0;
      end
      @(negedge clk);
      chk("seq_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("seq_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // Backpressure on the second byte
      ack_force = 1'b0;
      pulse_rise(32'h12345678, 1'b1);
      ready = 1'b0;
      @(posedge clk); #1;
      ack_force = 1'b1;
      @(posedge clk); #1;
      ack_force = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_byte", 32'(out_byte), 32'h34);
         @(posedge clk); #1;
      end
      ack_force = 1'b1;
      @(negedge clk);
      chk("hold_acked", 32'(out_byte), 32'h34);
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_hold", 32'(out_byte), 32'h56);
      wait_idle();

      // Product arriving mid-transfer is dropped
      ack_force = 1'b0;
      pulse_rise(32'h12345678, 1'b1);
      pulse_rise(32'hDEADBEEF, 1'b0);
      ready = 1'b0;
      @(negedge clk);
      chk("dropped_set", 32'(dropped), 32'd1);
      @(posedge clk); #1;
      ack_force = 1'b1;
      wait_idle();
      chk("dropped_sticky", 32'(dropped), 32'd1);

      // Zero product
      pulse_rise(32'h00000000, 1'b1);
      ready = 1'b0;
      wait_idle();
`ifdef LEADING_ZERO_SKIP_EN
      pulse_rise(32'h00000005, 1'b1);
      ready = 1'b0;
      wait_idle();
`endif

      // Randomized products with random acknowledge
      ack_rand = 1'b1;
      for (int n = 0; n < 30; n++) begin
         v = $urandom;
         v = v >> (8 * $urandom_range(0, 4));
         pulse_rise(v, 1'b1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         ready = 1'b0;
         wait_idle();
      end
      ack_rand = 1'b0;
      chk("dropped_still", 32'(dropped), 32'd1);

      // ready held high through reset release must not capture
      ready = 1'b1;
      do_reset();
      @(negedge clk);
      chk("rst_clears_dropped", 32'(dropped), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_capture", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      ack_force = 1'b1;
      pulse_rise(32'hA1B2C3D4, 1'b1);
      ready = 1'b0;
      wait_idle();

      // Reset while the second byte is pending aborts with no done pulse
      ack_force = 1'b0;
      pulse_rise(32'h12345678, 1'b1);
      ready = 1'b0;
      ack_force = 1'b1;
      @(posedge clk); #1;
      ack_force = 1'b0;
      @(negedge clk);
      chk("abort_pending", 32'(out_byte), 32'h34);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      ack_force = 1'b1;
      pulse_rise(32'h12345678, 1'b1);
      @(negedge clk);
      chk("restart_first", 32'(out_byte), 32'h12);
      @(posedge clk); #1;
      ready = 1'b0;
      wait_idle();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
